mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/common_types_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/common_types_pkg.sv
// Shared types for the memory-side blocks: the 32-bit data word and the
// arbiter state encoding, plus a small request decode helper.
package common_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    OACC = 2'd3
  } arb_state_t;

  // A port has work pending when it asks for a read or enables any byte write.
  function automatic logic is_pending(input logic ren, input logic [3:0] wen);
    return ren | (|wen);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction and data requesters with
// starvation protection. Defining RAM_DUMP_OVERRIDE_EN adds an override port.
module mem_arbiter
  import common_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iren,
  input  word_t      iaddr,
  output logic       iwait,
  output word_t      iload,
  input  logic       dren,
  input  logic [3:0] dwen,
  input  word_t      daddr,
  input  word_t      dstore,
  output logic       dwait,
  output word_t      dload,
`ifdef RAM_DUMP_OVERRIDE_EN
  input  logic       override_ctrl,
  input  logic       oren,
  input  logic [3:0] owen,
  input  word_t      oaddr,
  input  word_t      ostore,
  output word_t      oload,
  output logic       owait,
`endif
  output logic       ram_ren,
  output logic [3:0] ram_wen,
  output word_t      ram_addr,
  output word_t      ram_store,
  input  word_t      ram_load,
  input  logic       ram_ready
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  arb_state_t       state_r;
  arb_state_t       state_next_s;
  logic [CNT_W-1:0] starve_cnt_r;
  logic             d_pend_s;
  logic             i_first_s;

  assign d_pend_s  = is_pending(dren, dwen);
  // Instruction side wins when it has been passed over too often or data is idle.
  assign i_first_s = iren & ((starve_cnt_r == LIMIT_C) | ~d_pend_s);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Starvation counter: counts data grants taken while instructions wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == IACC) && ram_ready) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == DACC) && ram_ready && iren && (starve_cnt_r != LIMIT_C)) begin
      starve_cnt_r <= starve_cnt_r + ONE_C;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Next-state selection.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
`ifdef RAM_DUMP_OVERRIDE_EN
        if (override_ctrl) begin
          if (is_pending(oren, owen)) begin
            state_next_s = OACC;
          end else begin
            state_next_s = IDLE;
          end
        end else if (i_first_s) begin
          state_next_s = IACC;
        end else if (d_pend_s) begin
          state_next_s = DACC;
        end else begin
          state_next_s = IDLE;
        end
`else
        if (i_first_s) begin
          state_next_s = IACC;
        end else if (d_pend_s) begin
          state_next_s = DACC;
        end else begin
          state_next_s = IDLE;
        end
`endif
      end
      IACC, DACC, OACC: begin
        if (ram_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // RAM request mux and per-port completion; reset masks any in-flight access.
  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 4'b0000;
    ram_addr  = 32'h0000_0000;
    ram_store = 32'h0000_0000;
    iwait     = iren;
    dwait     = d_pend_s;
    iload     = 32'h0000_0000;
    dload     = 32'h0000_0000;
`ifdef RAM_DUMP_OVERRIDE_EN
    owait     = is_pending(oren, owen);
    oload     = 32'h0000_0000;
`endif
    if (rst) begin
      ram_ren = 1'b0;
    end else begin
      case (state_r)
        IACC: begin
          ram_ren  = 1'b1;
          ram_addr = iaddr;
          if (ram_ready) begin
            iwait = 1'b0;
            iload = ram_load;
          end else begin
            iload = 32'h0000_0000;
          end
        end
        DACC: begin
          // Any byte enable makes it a write, even with dren also set.
          ram_ren   = (dwen == 4'b0000);
          ram_wen   = dwen;
          ram_addr  = daddr;
          ram_store = dstore;
          if (ram_ready) begin
            dwait = 1'b0;
            dload = ram_load;
          end else begin
            dload = 32'h0000_0000;
          end
        end
`ifdef RAM_DUMP_OVERRIDE_EN
        OACC: begin
          ram_ren   = (owen == 4'b0000);
          ram_wen   = owen;
          ram_addr  = oaddr;
          ram_store = ostore;
          if (ram_ready) begin
            owait = 1'b0;
            oload = ram_load;
          end else begin
            oload = 32'h0000_0000;
          end
        end
`endif
        default: ram_ren = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (default build): reset, instruction read,
// data write, starvation ordering and reset mid-access.
module tb_mem_arbiter;
  import common_types_pkg::*;

  logic       clk;
  logic       rst;
  logic       iren;
  word_t      iaddr;
  logic       iwait;
  word_t      iload;
  logic       dren;
  logic [3:0] dwen;
  word_t      daddr;
  word_t      dstore;
  logic       dwait;
  word_t      dload;
  logic       ram_ren;
  logic [3:0] ram_wen;
  word_t      ram_addr;
  word_t      ram_store;
  word_t      ram_load;
  logic       ram_ready;

  int tests;
  int fails;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .iren(iren), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; iren = 1'b0; iaddr = 32'h0; dren = 1'b0; dwen = 4'h0;
    daddr = 32'h0; dstore = 32'h0; ram_load = 32'h0; ram_ready = 1'b0;

    // Reset: outputs quiet, waits mirror requests.
    @(negedge clk); #1;
    check("rst_ren", {31'h0, ram_ren}, 32'h0);
    check("rst_wen", {28'h0, ram_wen}, 32'h0);
    check("rst_addr", ram_addr, 32'h0);
    iren = 1'b1; dren = 1'b1; #1;
    check("rst_iwait", {31'h0, iwait}, 32'h1);
    check("rst_dwait", {31'h0, dwait}, 32'h1);
    @(negedge clk);
    iren = 1'b0; dren = 1'b0; rst = 1'b0; #1;
    check("idle_iwait", {31'h0, iwait}, 32'h0);

    // ram_ready in IDLE is ignored.
    ram_ready = 1'b1; ram_load = 32'h5555_AAAA; #1;
    check("idle_rdy_iload", iload, 32'h0);
    check("idle_rdy_dload", dload, 32'h0);
    check("idle_rdy_ren", {31'h0, ram_ren}, 32'h0);

    // Instruction read, ready three cycles after grant.
    @(negedge clk);
    ram_ready = 1'b0; ram_load = 32'h0; iren = 1'b1; iaddr = 32'h100; #1;
    check("i_idle_ren", {31'h0, ram_ren}, 32'h0);
    check("i_idle_iwait", {31'h0, iwait}, 32'h1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check("i_acc_ren", {31'h0, ram_ren}, 32'h1);
      check("i_acc_addr", ram_addr, 32'h100);
      check("i_acc_iwait", {31'h0, iwait}, 32'h1);
      check("i_acc_iload", iload, 32'h0);
    end
    @(negedge clk);
    ram_ready = 1'b1; ram_load = 32'hDEAD_BEEF; #1;
    check("i_done_iwait", {31'h0, iwait}, 32'h0);
    check("i_done_iload", iload, 32'hDEAD_BEEF);
    @(negedge clk);
    iren = 1'b0; ram_ready = 1'b0; #1;
    check("i_back_idle_ren", {31'h0, ram_ren}, 32'h0);
    check("i_back_idle_addr", ram_addr, 32'h0);

    // Data write with dren also set.
    dren = 1'b1; dwen = 4'b0011; daddr = 32'h40; dstore = 32'h1234; #1;
    check("d_idle_dwait", {31'h0, dwait}, 32'h1);
    check("d_idle_wen", {28'h0, ram_wen}, 32'h0);
    @(negedge clk); #1;
    check("d_acc_ren", {31'h0, ram_ren}, 32'h0);
    check("d_acc_wen", {28'h0, ram_wen}, 32'h3);
    check("d_acc_addr", ram_addr, 32'h40);
    check("d_acc_store", ram_store, 32'h1234);
    check("d_acc_dwait", {31'h0, dwait}, 32'h1);
    @(negedge clk);
    ram_ready = 1'b1; ram_load = 32'hCAFE_F00D; #1;
    check("d_done_wen", {28'h0, ram_wen}, 32'h3);
    check("d_done_dwait", {31'h0, dwait}, 32'h0);
    check("d_done_dload", dload, 32'hCAFE_F00D);
    @(negedge clk);
    dren = 1'b0; dwen = 4'h0; ram_ready = 1'b0; #1;
    check("d_back_idle_wen", {28'h0, ram_wen}, 32'h0);

    // Both requesting, instant ready: D,D,D,D,I repeating.
    iren = 1'b1; iaddr = 32'h100; dren = 1'b1; daddr = 32'h200; ram_ready = 1'b1;
    for (int g = 0; g < 10; g++) begin
      #1;
      check("starve_idle_ren", {31'h0, ram_ren}, 32'h0);
      @(negedge clk); #1;
      check("starve_addr", ram_addr, ((g % 5) == 4) ? 32'h100 : 32'h200);
      check("starve_iwait", {31'h0, iwait}, ((g % 5) == 4) ? 32'h0 : 32'h1);
      check("starve_dwait", {31'h0, dwait}, ((g % 5) == 4) ? 32'h1 : 32'h0);
      @(negedge clk);
    end

    // Two data writes bring the counter to 2, then reset hits the third.
    dwen = 4'hF;
    for (int g = 0; g < 2; g++) begin
      @(negedge clk); #1;
      check("pre_rst_wen", {28'h0, ram_wen}, 32'hF);
      @(negedge clk);
    end
    ram_ready = 1'b0;
    @(negedge clk); #1;
    check("mid_dacc_wen", {28'h0, ram_wen}, 32'hF);
    check("mid_dacc_addr", ram_addr, 32'h200);
    @(negedge clk);
    rst = 1'b1; #1;
    check("rst_mid_wen", {28'h0, ram_wen}, 32'h0);
    check("rst_mid_addr", ram_addr, 32'h0);
    check("rst_mid_dwait", {31'h0, dwait}, 32'h1);
    @(negedge clk);
    rst = 1'b0; #1;
    check("post_rst_wen", {28'h0, ram_wen}, 32'h0);
    check("post_rst_dwait", {31'h0, dwait}, 32'h1);

    // Counter cleared by reset: four data grants before the instruction.
    ram_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk); #1;
      check("post_rst_order", ram_addr, (g == 4) ? 32'h100 : 32'h200);
      @(negedge clk);
    end

    iren = 1'b0; dren = 1'b0; dwen = 4'h0; ram_ready = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
